// File: rtl/line_scan_out_pkg.sv
// Shared constants and state encoding for the terrain line scan-out reader.
package line_scan_out_pkg;

    localparam int LINE_W       = 640;
    localparam int LINE_XW      = 10;
    localparam int HOLE_MIN_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/line_hole_detect.sv
// Zero-run tracker: flags a hole once per run when the run reaches HOLE_MIN
// and remembers the x of the pixel that completed it.
module line_hole_detect
    import line_scan_out_pkg::*;
#(
    parameter int XW       = LINE_XW,
    parameter int HOLE_MIN = HOLE_MIN_DEF
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          bit_valid_i,
    input  logic          bit_i,
    input  logic [XW-1:0] x_i,
    output logic          hole_o,
    output logic [XW-1:0] hole_x_o
);

    localparam logic [XW-1:0] RUN_SAT = XW'(HOLE_MIN);

    logic [XW-1:0] run_r;
    logic [XW-1:0] run_next_s;
    logic          hit_s;
    logic          hole_r;
    logic [XW-1:0] hole_x_r;

    // Next run length; saturating at RUN_SAT means the hit fires only once per run
    always_comb begin
        run_next_s = run_r;
        hit_s      = 1'b0;
        if (clr_i) begin
            run_next_s = '0;
        end else if (bit_valid_i) begin
            if (bit_i) begin
                run_next_s = '0;
            end else begin
                hit_s = (run_r == (RUN_SAT - XW'(1)));
                if (run_r != RUN_SAT) begin
                    run_next_s = run_r + XW'(1);
                end else begin
                    run_next_s = run_r;
                end
            end
        end else begin
            run_next_s = run_r;
        end
    end

    // Run counter, hole pulse and hole position registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            run_r    <= '0;
            hole_r   <= 1'b0;
            hole_x_r <= '0;
        end else begin
            run_r  <= run_next_s;
            hole_r <= hit_s;
            if (hit_s) begin
                hole_x_r <= x_i;
            end
        end
    end

    assign hole_o   = hole_r;
    assign hole_x_o = hole_x_r;

endmodule

// File: rtl/line_scan_out.sv
// Snapshots a terrain line on row start and serializes it LSB first, one
// pixel per pix_en_i, with hole detection and per-scan set-bit count.
module line_scan_out
    import line_scan_out_pkg::*;
#(
    parameter int WIDTH    = LINE_W,
    parameter int XW       = LINE_XW,
    parameter int HOLE_MIN = HOLE_MIN_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] line_i,
    input  logic             pix_en_i,
    output logic             pix_o,
    output logic             pix_valid_o,
    output logic [XW-1:0]    pix_x_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             hole_o,
    output logic [XW-1:0]    hole_x_o,
    output logic [XW-1:0]    ones_cnt_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shadow_r;
    logic [XW-1:0]    x_r;
    logic [XW-1:0]    ones_acc_r;
    logic [XW-1:0]    ones_next_s;
    logic             step_s;
    logic             last_s;
    logic             pix_r;
    logic             pix_valid_r;
    logic [XW-1:0]    pix_x_r;
    logic             done_r;
    logic [XW-1:0]    ones_cnt_r;

    assign ones_next_s = ones_acc_r + {{(XW-1){1'b0}}, shadow_r[0]};

    // Next state and pixel-step qualifiers; a load always wins over pix_en_i
    always_comb begin
        state_next_s = state_r;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_i) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (load_i) begin
                    state_next_s = SCAN;
                end else if (pix_en_i) begin
                    step_s = 1'b1;
                    if (x_r == X_LAST) begin
                        last_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = SCAN;
                    end
                end else begin
                    state_next_s = SCAN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow shifter, counters and registered pixel outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shadow_r    <= '0;
            x_r         <= '0;
            ones_acc_r  <= '0;
            pix_r       <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_x_r     <= '0;
            done_r      <= 1'b0;
            ones_cnt_r  <= '0;
        end else begin
            pix_valid_r <= step_s;
            done_r      <= last_s;
            if (load_i) begin
                shadow_r   <= line_i;
                x_r        <= '0;
                ones_acc_r <= '0;
            end else if (step_s) begin
                shadow_r   <= {1'b0, shadow_r[WIDTH-1:1]};
                x_r        <= x_r + XW'(1);
                ones_acc_r <= ones_next_s;
                pix_r      <= shadow_r[0];
                pix_x_r    <= x_r;
                if (last_s) begin
                    ones_cnt_r <= ones_next_s;
                end
            end
        end
    end

    line_hole_detect #(
        .XW       (XW),
        .HOLE_MIN (HOLE_MIN)
    ) u_hole (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (load_i),
        .bit_valid_i (step_s),
        .bit_i       (shadow_r[0]),
        .x_i         (x_r),
        .hole_o      (hole_o),
        .hole_x_o    (hole_x_o)
    );

    assign pix_o       = pix_r;
    assign pix_valid_o = pix_valid_r;
    assign pix_x_o     = pix_x_r;
    assign busy_o      = (state_r == SCAN);
    assign done_o      = done_r;
    assign ones_cnt_o  = ones_cnt_r;

endmodule

// File: tb/tb_line_scan_out.sv
// Randomized scoreboard bench for line_scan_out: stimulus pushes expected
// pixels from a line-level model, a negedge monitor pops and compares.
module tb_line_scan_out;
    import line_scan_out_pkg::*;

    localparam int W  = LINE_W;
    localparam int XW = LINE_XW;
    localparam int HM = HOLE_MIN_DEF;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          load_i = 1'b0;
    logic [W-1:0]  line_i = '0;
    logic          pix_en_i = 1'b0;
    logic          pix_o, pix_valid_o, busy_o, done_o, hole_o;
    logic [XW-1:0] pix_x_o, hole_x_o, ones_cnt_o;

    typedef struct {
        logic pix;
        int   x;
        logic hole;
        logic done;
        int   ones;
        int   cyc;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   exp_ones_m = 0;
    int   exp_hole_x_m = 0;

    line_scan_out dut (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .line_i(line_i),
        .pix_en_i(pix_en_i), .pix_o(pix_o), .pix_valid_o(pix_valid_o),
        .pix_x_o(pix_x_o), .busy_o(busy_o), .done_o(done_o), .hole_o(hole_o),
        .hole_x_o(hole_x_o), .ones_cnt_o(ones_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every presented pixel must match the oldest expected one
    always @(negedge clk_i) begin
        if (reset_i) begin
            if (pix_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    e_m = q.pop_front();
                    chk("pix", int'(pix_o), int'(e_m.pix));
                    chk("pix_x", int'(pix_x_o), e_m.x);
                    chk("hole", int'(hole_o), int'(e_m.hole));
                    chk("done", int'(done_o), int'(e_m.done));
                    chk("latency", cyc, e_m.cyc + 1);
                    if (e_m.done) chk("ones_cnt_at_done", int'(ones_cnt_o), e_m.ones);
                end
            end else begin
                if (hole_o) chk("hole_without_pixel", 1, 0);
                if (done_o) chk("done_without_pixel", 1, 0);
            end
        end
    end

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] l;
        int i;
        logic v;
        int n;
        l = '0;
        i = 0;
        while (i < W) begin
            v = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 24);
            for (int k = 0; k < n && i < W; k++) begin
                l[i] = v;
                i++;
            end
        end
        return l;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix"}, int'(pix_o), 0);
        chk({tag, "_pix_valid"}, int'(pix_valid_o), 0);
        chk({tag, "_pix_x"}, int'(pix_x_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_hole"}, int'(hole_o), 0);
        chk({tag, "_hole_x"}, int'(hole_x_o), 0);
        chk({tag, "_ones_cnt"}, int'(ones_cnt_o), 0);
    endtask

    // Loads ln, then issues pixels with gaps in [gmin,gmax]; stops before x==abort_at
    task automatic scan(input logic [W-1:0] ln, input int gmin, input int gmax, input int abort_at);
        int  run;
        int  ones;
        logic hole[W];
        run  = 0;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            if (ln[i]) run = 0;
            else run++;
            hole[i] = !ln[i] && (run == HM);
            ones += int'(ln[i]);
        end
        @(posedge clk_i); #1;
        load_i   = 1'b1;
        line_i   = ln;
        pix_en_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        load_i   = 1'b0;
        pix_en_i = 1'b0;
        chk("busy_after_load", int'(busy_o), 1);
        chk("ones_cnt_hold", int'(ones_cnt_o), exp_ones_m);
        for (int x = 0; x < W; x++) begin
            if (x == abort_at) return;
            repeat ($urandom_range(gmin, gmax)) begin
                @(posedge clk_i); #1;
            end
            pix_en_i = 1'b1;
            q.push_back('{pix: ln[x], x: x, hole: hole[x], done: (x == W - 1),
                          ones: ones, cyc: cyc});
            if (hole[x]) exp_hole_x_m = x;
            @(posedge clk_i); #1;
            pix_en_i = 1'b0;
        end
        exp_ones_m = ones;
        repeat (3) @(posedge clk_i);
        #1;
        chk("ones_cnt_final", int'(ones_cnt_o), exp_ones_m);
        chk("busy_after_scan", int'(busy_o), 0);
        chk("hole_x_held", int'(hole_x_o), exp_hole_x_m);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ln;
        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        reset_i = 1'b1;

        scan('1, 0, 0, -1);

        ln = '1;
        for (int i = 100; i <= 115; i++) ln[i] = 1'b0;
        scan(ln, 0, 0, -1);

        ln = '1;
        for (int i = 200; i <= 214; i++) ln[i] = 1'b0;
        scan(ln, 0, 0, -1);

        ln = rand_line();
        scan(ln, 0, 0, -1);
        scan(ln, 2, 2, -1);

        scan(rand_line(), 0, 3, 300);
        scan('0, 0, 1, -1);

        for (int r = 0; r < 3; r++) scan(rand_line(), 0, 2, -1);

        scan(rand_line(), 0, 1, 50);
        pix_en_i = 1'b0;
        reset_i  = 1'b0;
        #1;
        check_all_zero("mid_reset");
        q.delete();
        exp_ones_m   = 0;
        exp_hole_x_m = 0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        pix_en_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        chk("no_pixel_without_load", int'(pix_valid_o), 0);
        chk("idle_after_reset", int'(busy_o), 0);
        pix_en_i = 1'b0;

        scan(rand_line(), 0, 1, -1);

        repeat (2) @(posedge clk_i);
        chk("final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/line_scan_out.md
Name: line_scan_out

Overview:
- Reader for the 640-bit terrain line produced by the line generator.
- Snapshots the line on a row-start strobe, then serializes it one pixel per pixel-enable tick, LSB first, into the VGA colour path.
- Also detects holes (zero runs) for game collision logic, and counts set bits per completed scan for scoring/debug.

Parameters:
- WIDTH, 640, line width in bits/pixels.
- XW, 10, width of pixel index and counters; requires 2^XW > WIDTH.
- HOLE_MIN, 16, zero-run length at which a hole is flagged; legal range 1..WIDTH.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  reset, asynchronous, active-low.
- load_i  input  1  row-start strobe; captures line_i.
- line_i  input  WIDTH  line from the generator; bit 0 is displayed at x=0.
- pix_en_i  input  1  one pulse per active-video pixel.
- pix_o  output  1  current pixel bit (1 = ground, 0 = empty).
- pix_valid_o  output  1  pix_o/pix_x_o valid this cycle.
- pix_x_o  output  XW  x index of pix_o.
- busy_o  output  1  high while in SCAN.
- done_o  output  1  one-cycle pulse after the last pixel is emitted.
- hole_o  output  1  one-cycle pulse when a zero run reaches HOLE_MIN.
- hole_x_o  output  XW  x of the pixel that completed the hole; held until the next hole.
- ones_cnt_o  output  XW  number of 1 pixels in the last completed scan.

Behaviour:
- Reset (async, reset_i=0) values:
  - State IDLE; shadow register 0; x counter 0; run counter 0.
  - All outputs 0.
- States: IDLE, SCAN.
- IDLE:
  - load_i=1 -> shadow<=line_i, x<=0, run<=0, ones_acc<=0, go SCAN.
  - pix_en_i is ignored in IDLE.
- SCAN, per cycle with pix_en_i=1 and load_i=0:
  - Next cycle: pix_o=shadow[0], pix_x_o=x, pix_valid_o=1. Latency is 1 clk from pix_en_i.
  - shadow shifts right by 1; x<=x+1.
  - ones_acc<=ones_acc+shadow[0].
  - shadow[0]=0 -> run<=run+1, saturating at HOLE_MIN. shadow[0]=1 -> run<=0.
  - When run+1 == HOLE_MIN on a 0 bit: hole_o pulses together with that pixel's pix_valid_o, and hole_x_o<=x.
  - hole_o pulses once per run; further zeros in the same run do not re-fire.
- Last pixel (x == WIDTH-1 with pix_en_i):
  - Pixel is emitted normally.
  - Same cycle as its pix_valid_o: done_o=1, ones_cnt_o<=final count including the last bit, busy_o falls, state IDLE.
- SCAN with pix_en_i=0: all state held; pix_valid_o=0, hole_o=0.
- load_i during SCAN (resync): abort the current scan.
  - No done_o; ones_cnt_o unchanged.
  - Re-capture line_i; x, run, ones_acc cleared; stay in SCAN.
  - load_i wins over a simultaneous pix_en_i, which is dropped.
- load_i and the last pix_en_i in the same cycle: load_i wins, no done_o.
- Holes never span scans: run is cleared on load. A run ending at x=WIDTH-1 counts if it reaches HOLE_MIN.
- pix_o and pix_x_o hold their last value when pix_valid_o=0.
- Reset mid-scan: immediate return to reset values; any partial count is lost.
- Widths: ones_acc and ones_cnt_o are XW bits; max value WIDTH, no overflow since 2^XW > WIDTH.

Decomposition:
- Shared package holds:
  - LINE_W=640, LINE_XW=10.
  - State encoding: IDLE=1'b0, SCAN=1'b1.
  - Default HOLE_MIN.
- One natural sub-module: line_hole_detect. It contains the run counter, saturation, hole pulse and hole_x capture; it is fed bit/valid/x from the serializer.
- Serializer and FSM stay in the top module.

Test Plan:
- Reset, line_i=all 1, load, 640 continuous pix_en -> 640 pix_valid with pix_o=1 and x=0..639; done_o at x=639; ones_cnt_o=640; no hole_o.
- line_i with bits 100..115 = 0, rest 1, HOLE_MIN=16 -> exactly one hole_o, coincident with x=115, hole_x_o=115; ones_cnt_o=624.
- line_i with bits 200..214 = 0 (15 zeros), rest 1 -> no hole_o; ones_cnt_o=625.
- pix_en_i every 3rd cycle -> pix_valid_o rate matches, 1-clk latency each; pixel sequence identical to continuous case.
- load_i asserted at x=300 with a new line of all 0 -> no done_o; x restarts at 0; hole_o at x=15; final ones_cnt_o=0; done_o at x=639.
- reset_i low at x=50 -> all outputs 0 asynchronously, busy_o=0; pix_en_i without load produces no pix_valid_o.
